// File: rtl/wb_port_arbiter_if.sv
// Writeback arbiter bus: two writeback requesters plus the GPR/CSR write ports.
// The arbiter takes the slave modport and the environment takes the master modport.
interface wb_port_arbiter_if #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int CSR_AW = 12
);
    // req0: in-order MEM/WB path
    logic              wb0_valid_i;
    logic              wb0_ready_o;
    logic [XLEN-1:0]   wb0_data_i;
    logic [REG_AW-1:0] wb0_rd_idx_i;
    logic [CSR_AW-1:0] wb0_csr_addr_i;
    logic [XLEN-1:0]   wb0_csr_data_i;
    logic              wb0_csr_valid_i;
    // req1: long-latency unit
    logic              wb1_valid_i;
    logic              wb1_ready_o;
    logic [XLEN-1:0]   wb1_data_i;
    logic [REG_AW-1:0] wb1_rd_idx_i;
    // register file write ports
    logic              gpr_wen_o;
    logic [REG_AW-1:0] gpr_waddr_o;
    logic [XLEN-1:0]   gpr_wdata_o;
    logic              csr_wen_o;
    logic [CSR_AW-1:0] csr_waddr_o;
    logic [XLEN-1:0]   csr_wdata_o;
    logic [31:0]       stall_cnt_o;

    modport slave (
        input  wb0_valid_i, wb0_data_i, wb0_rd_idx_i, wb0_csr_addr_i, wb0_csr_data_i, wb0_csr_valid_i,
        input  wb1_valid_i, wb1_data_i, wb1_rd_idx_i,
        output wb0_ready_o, wb1_ready_o,
        output gpr_wen_o, gpr_waddr_o, gpr_wdata_o,
        output csr_wen_o, csr_waddr_o, csr_wdata_o,
        output stall_cnt_o
    );

    modport master (
        output wb0_valid_i, wb0_data_i, wb0_rd_idx_i, wb0_csr_addr_i, wb0_csr_data_i, wb0_csr_valid_i,
        output wb1_valid_i, wb1_data_i, wb1_rd_idx_i,
        input  wb0_ready_o, wb1_ready_o,
        input  gpr_wen_o, gpr_waddr_o, gpr_wdata_o,
        input  csr_wen_o, csr_waddr_o, csr_wdata_o,
        input  stall_cnt_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the GPR and CSR write ports between the MEM/WB path (wb0)
// and the long-latency unit (wb1). wb0 has fixed priority; wb1 wins once it has lost
// STARVE_MAX consecutive contended cycles. Write ports are registered (latency 1).
// Optional macro WB_PERF_EN adds a 32-bit wb1 stall-cycle counter on stall_cnt_o.
module wb_port_arbiter #(
    parameter int XLEN       = 64,
    parameter int REG_AW     = 5,
    parameter int CSR_AW     = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_port_arbiter_if.slave     wb
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef struct packed {
        logic              gpr_wen;
        logic [REG_AW-1:0] gpr_waddr;
        logic [XLEN-1:0]   gpr_wdata;
        logic              csr_wen;
        logic [CSR_AW-1:0] csr_waddr;
        logic [XLEN-1:0]   csr_wdata;
    } wr_port_t;

    logic [3:0] starve_cnt;
    logic       grant0;
    logic       grant1;
    wr_port_t   wr_q;
    wr_port_t   wr_nxt;

    // Grant decision: wb0 first, wb1 when alone or once starvation saturates; none during reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (wb.wb0_valid_i && !(wb.wb1_valid_i && starve_cnt == STARVE_LIM))
                grant0 = 1'b1;
            else if (wb.wb1_valid_i)
                grant1 = 1'b1;
        end
    end

    assign wb.wb0_ready_o = grant0;
    assign wb.wb1_ready_o = grant1;

    // Next write-port contents; all-zero when nothing is granted. x0 writes are accepted but not enabled.
    always_comb begin
        wr_nxt = '0;
        if (grant0) begin
            wr_nxt.gpr_wen   = (wb.wb0_rd_idx_i != '0);
            wr_nxt.gpr_waddr = wb.wb0_rd_idx_i;
            wr_nxt.gpr_wdata = wb.wb0_data_i;
            if (wb.wb0_csr_valid_i) begin
                wr_nxt.csr_wen   = 1'b1;
                wr_nxt.csr_waddr = wb.wb0_csr_addr_i;
                wr_nxt.csr_wdata = wb.wb0_csr_data_i;
            end
        end else if (grant1) begin
            wr_nxt.gpr_wen   = (wb.wb1_rd_idx_i != '0);
            wr_nxt.gpr_waddr = wb.wb1_rd_idx_i;
            wr_nxt.gpr_wdata = wb.wb1_data_i;
        end
    end

    // Registered write ports; reset drops any coinciding grant.
    always_ff @(posedge clk) begin
        if (rst) wr_q <= '0;
        else     wr_q <= wr_nxt;
    end

    // Consecutive-loss counter for wb1; clears on a wb1 win or when wb1 stops asking.
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (!wb.wb1_valid_i || grant1)
            starve_cnt <= '0;
        else if (starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + 4'd1;
    end

    assign wb.gpr_wen_o   = wr_q.gpr_wen;
    assign wb.gpr_waddr_o = wr_q.gpr_waddr;
    assign wb.gpr_wdata_o = wr_q.gpr_wdata;
    assign wb.csr_wen_o   = wr_q.csr_wen;
    assign wb.csr_waddr_o = wr_q.csr_waddr;
    assign wb.csr_wdata_o = wr_q.csr_wdata;

`ifdef WB_PERF_EN
    logic [31:0] stall_cnt;

    // Free-running wb1 stall counter, wraps at 2^32.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (wb.wb1_valid_i && !grant1)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign wb.stall_cnt_o = stall_cnt;
`else
    assign wb.stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model.
module tb_wb_port_arbiter;

    localparam int XLEN  = 64;
    localparam int RAW   = 5;
    localparam int CAW   = 12;
    localparam int SMAX  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.XLEN(XLEN), .REG_AW(RAW), .CSR_AW(CAW)) bus ();

    wb_port_arbiter #(.XLEN(XLEN), .REG_AW(RAW), .CSR_AW(CAW), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int          lost_streak = 0;   // consecutive cycles wb1 waited and lost
    logic [31:0] m_stall = '0;
    logic            e_gwen = 1'b0;
    logic [RAW-1:0]  e_gaddr = '0;
    logic [XLEN-1:0] e_gdata = '0;
    logic            e_cwen = 1'b0;
    logic [CAW-1:0]  e_caddr = '0;
    logic [XLEN-1:0] e_cdata = '0;
    int          wb1_x7_writes = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check the combinational grants, advance the clock,
    // then check the registered write ports and the stall counter.
    task automatic step(input logic r,
                        input logic v0, input logic [XLEN-1:0] d0, input logic [RAW-1:0] rd0,
                        input logic cv, input logic [CAW-1:0] ca, input logic [XLEN-1:0] cd,
                        input logic v1, input logic [XLEN-1:0] d1, input logic [RAW-1:0] rd1);
        logic g0, g1;
        rst = r;
        bus.wb0_valid_i = v0;  bus.wb0_data_i = d0;  bus.wb0_rd_idx_i = rd0;
        bus.wb0_csr_valid_i = cv; bus.wb0_csr_addr_i = ca; bus.wb0_csr_data_i = cd;
        bus.wb1_valid_i = v1;  bus.wb1_data_i = d1;  bus.wb1_rd_idx_i = rd1;
        #2;
        // wb0 wins unless wb1 is also asking and has already lost SMAX times in a row
        g0 = !r && v0 && !(v1 && lost_streak >= SMAX);
        g1 = !r && v1 && !g0;
        chk("wb0_ready", 64'(bus.wb0_ready_o), 64'(g0));
        chk("wb1_ready", 64'(bus.wb1_ready_o), 64'(g1));

        @(posedge clk);
        {e_gwen, e_gaddr, e_gdata, e_cwen, e_caddr, e_cdata} = '0;
        if (g0) begin
            e_gwen = (rd0 != 0); e_gaddr = rd0; e_gdata = d0;
            if (cv) begin e_cwen = 1'b1; e_caddr = ca; e_cdata = cd; end
        end else if (g1) begin
            e_gwen = (rd1 != 0); e_gaddr = rd1; e_gdata = d1;
            if (rd1 == 7) wb1_x7_writes++;
        end
        if (r) begin
            lost_streak = 0;
            m_stall = '0;
        end else begin
            if (v1 && !g1) begin
                lost_streak = (lost_streak < SMAX) ? lost_streak + 1 : SMAX;
                m_stall = m_stall + 32'd1;
            end else begin
                lost_streak = 0;
            end
        end
        #1;
        chk("gpr_wen",   64'(bus.gpr_wen_o),   64'(e_gwen));
        chk("gpr_waddr", 64'(bus.gpr_waddr_o), 64'(e_gaddr));
        chk("gpr_wdata", bus.gpr_wdata_o,      e_gdata);
        chk("csr_wen",   64'(bus.csr_wen_o),   64'(e_cwen));
        chk("csr_waddr", 64'(bus.csr_waddr_o), 64'(e_caddr));
        chk("csr_wdata", bus.csr_wdata_o,      e_cdata);
`ifdef WB_PERF_EN
        chk("stall_cnt", 64'(bus.stall_cnt_o), 64'(m_stall));
`else
        chk("stall_cnt", 64'(bus.stall_cnt_o), 64'd0);
`endif
    endtask

    task automatic idle(input logic r);
        step(r, 0, '0, '0, 0, '0, '0, 0, '0, '0);
    endtask

    initial begin
        int x7_before;
        rst = 1'b1;
        bus.wb0_valid_i = 0; bus.wb0_data_i = '0; bus.wb0_rd_idx_i = '0;
        bus.wb0_csr_valid_i = 0; bus.wb0_csr_addr_i = '0; bus.wb0_csr_data_i = '0;
        bus.wb1_valid_i = 0; bus.wb1_data_i = '0; bus.wb1_rd_idx_i = '0;
        @(posedge clk); #1;

        // reset state
        idle(1); idle(1); idle(0);

        // wb0 only, rd=5
        step(0, 1, 64'h1234, 5'd5, 0, '0, '0, 0, '0, '0);
        idle(0);
        // x0 write with CSR write
        step(0, 1, 64'hdead, 5'd0, 1, 12'h305, 64'h8000_0000, 0, '0, '0);
        idle(0);

        // continuous contention: 4 wb0 grants then wb1, twice
        x7_before = wb1_x7_writes;
        for (int i = 0; i < 10; i++)
            step(0, 1, 64'(100 + i), 5'd3, 0, '0, '0, 1, 64'hbeef, 5'd7);
        chk("wb1_x7_count", 64'(wb1_x7_writes - x7_before), 64'd2);
        idle(0);

        // starve to 3, wb1 alone clears, drop, then contention again
        for (int i = 0; i < 3; i++)
            step(0, 1, 64'(i), 5'd4, 0, '0, '0, 1, 64'h77, 5'd9);
        step(0, 0, '0, '0, 0, '0, '0, 1, 64'h77, 5'd9);
        idle(0);
        for (int i = 0; i < 6; i++)
            step(0, 1, 64'(200 + i), 5'd6, 0, '0, '0, 1, 64'h88, 5'd10);
        idle(0);

        // reset in the cycle wb1 would win
        for (int i = 0; i < 4; i++)
            step(0, 1, 64'(i), 5'd1, 1, 12'h300, 64'h5, 1, 64'h99, 5'd2);
        step(1, 1, 64'h11, 5'd1, 1, 12'h300, 64'h5, 1, 64'h99, 5'd2);
        idle(1);
        idle(0);

        // wb1 blocked 4 cycles from a clean stall count
        idle(1);
        for (int i = 0; i < 4; i++)
            step(0, 1, 64'(i), 5'd8, 0, '0, '0, 1, 64'h1, 5'd12);
        idle(0);

        // random traffic, biased towards contention
        for (int i = 0; i < 1500; i++) begin
            logic [RAW-1:0] r0, r1;
            r0 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            r1 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            step($urandom_range(0, 40) == 0,
                 $urandom_range(0, 3) != 0, {$urandom, $urandom}, r0,
                 1'($urandom), 12'($urandom), {$urandom, $urandom},
                 $urandom_range(0, 3) != 0, {$urandom, $urandom}, r1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
